pipeline_hazard_controller: RTL
===============================

# pipeline_hazard_controller

Sequencer for the Filter-GPU 5-stage pipeline buffers. It drives the load enables of the fetch, decode, execute, memory and writeback registers, and the synchronous flush of the decode/execute buffer. It detects load-use hazards, freezes the pipe on memory wait, drains the pipe on halt, and produces execute-stage forwarding selects. It sits beside the vector datapath and owns every pipeline-buffer `load`/`reset` qualifier except global reset.

## Interface
- TIMEOUT, 255: max consecutive memory-wait cycles before the block enters ERROR.
- DRAIN_CYCLES, 3: cycles spent draining E/M/W after a halt.
- CNT_W, 16: width of the stall counter.

- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; dominates every other input.
- start  in  1  begin or restart execution (sampled in IDLE/DONE).
- ra1D, ra2D  in  4  decode-stage source registers.
- ra1E, ra2E  in  4  execute-stage source registers (ID/EX buffer outputs).
- WA3E, WA3M, WA3W  in  4  destination register per stage.
- RegWriteE, RegWriteM, RegWriteW  in  1  write-enable per stage.
- MemtoRegE  in  1  execute-stage instruction is a load.
- haltD  in  1  decode-stage instruction is HALT.
- mem_req  in  1  memory-stage access pending.
- mem_ready  in  1  memory completes access this cycle.
- loadF, loadD, loadE, loadM, loadW  out  1  buffer load enables.
- flushE  out  1  synchronous clear of the ID/EX buffer (bubble).
- forwardAE, forwardBE  out  2  00 = register file, 10 = M-stage result, 01 = W-stage result.
- busy  out  1  high in RUN, MEM_WAIT and DRAIN.
- done  out  1  high in DONE.
- error  out  1  high in ERROR.
- stall_count  out  CNT_W  saturating count of frozen or stalled decode cycles.

## Operation
- States: IDLE, RUN, MEM_WAIT, DRAIN, DONE, ERROR. State and counters are registered. All other outputs are combinational from state and inputs.
- Definitions:
  - lu = RUN & MemtoRegE & RegWriteE & (WA3E==ra1D | WA3E==ra2D).
  - mw = mem_req & !mem_ready.
- IDLE: all loads 0, flushE 0. On start → RUN; stall_count and counters clear to 0.
- RUN: default is all loads 1, flushE 0.
  - Priority 1, mw: all loads 0, flushE 0 (freeze wins over lu). Next state MEM_WAIT, wait counter := 1.
  - Priority 2, lu: loadF=loadD=0, flushE=1, loadE=loadM=loadW=1.
  - Priority 3, haltD with no lu/mw: loadF=loadD=0, flushE=1. Next state DRAIN, drain counter := 0.
- MEM_WAIT:
  - While mw: all loads 0; wait counter increments.
  - If the counter reaches TIMEOUT while mw still holds → ERROR.
  - When mem_ready=1: same cycle behaves as RUN (lu/haltD evaluated normally). Next state RUN or DRAIN, as RUN would choose.
- DRAIN: loadF=loadD=0, flushE=1, loadE=loadM=loadW=1.
  - mw freezes all loads, flushE 0, and holds the drain counter.
  - The drain counter increments on unfrozen cycles. After DRAIN_CYCLES unfrozen cycles → DONE.
- DONE: all loads 0, done=1. start → RUN with counters cleared.
- ERROR: all loads 0, error=1. Sticky until reset.
- stall_count increments by 1 each cycle in RUN/MEM_WAIT/DRAIN where mw or lu holds. It saturates at 2^CNT_W−1.
- Forwarding (all states):
  - forwardAE=10 if RegWriteM & WA3M==ra1E.
  - Else forwardAE=01 if RegWriteW & WA3W==ra1E.
  - Else forwardAE=00.
  - forwardBE follows the same rules using ra2E. M takes priority over W.

## Timing
- Reset values: state IDLE; all loads 0; flushE 0; forwardAE/BE 00 (with zero inputs); busy 0; done 0; error 0; stall_count 0; counters 0.
- Reset mid-operation (any state): IDLE on the next edge; no partial drain.
- Load-use costs exactly 1 bubble. The load moves to M on the next edge, so lu drops.
- start→busy latency is 1 cycle. Halt→done latency is DRAIN_CYCLES+1 cycles with no memory stalls.
- start asserted in RUN/MEM_WAIT/DRAIN is ignored.
- haltD together with mw: freeze is applied and halt is re-evaluated when mem_ready rises.
- TIMEOUT counts cycles: ERROR is entered on the edge after TIMEOUT consecutive mw cycles.

## Test plan
- Reset then start with no hazards → after 1 cycle busy=1 and all loads 1; stall_count stays 0.
- MemtoRegE=1, RegWriteE=1, WA3E=5, ra1D=5 in RUN → one cycle of loadF=loadD=0 and flushE=1; stall_count=1.
- mem_req=1, mem_ready=0 for 4 cycles, then 1 → all loads 0 for 4 cycles, RUN resumes, stall_count=4. Add lu in the same cycle: flushE must be 0.
- haltD in RUN with no stalls → DRAIN for 3 cycles, then done=1 and busy=0; start → RUN with stall_count=0.
- mem_req held with mem_ready=0 and TIMEOUT=8 → error=1 after 8 cycles, all loads 0. Stays in ERROR until reset, then IDLE.
- RegWriteM=1, WA3M=3; RegWriteW=1, WA3W=3; ra1E=3; ra2E=3 with RegWriteM=0 → forwardAE=10 (M priority); forwardBE=01 in the second case.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Pipeline-buffer sequencer: load enables, ID/EX bubble flush, load-use and memory-wait
// stalls, halt drain, and execute-stage forwarding selects for the 5-stage pipe.
module pipeline_hazard_controller #(
   parameter int TIMEOUT      = 255,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       ra1D,
   input  logic [3:0]       ra2D,
   input  logic [3:0]       ra1E,
   input  logic [3:0]       ra2E,
   input  logic [3:0]       WA3E,
   input  logic [3:0]       WA3M,
   input  logic [3:0]       WA3W,
   input  logic             RegWriteE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             MemtoRegE,
   input  logic             haltD,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             loadF,
   output logic             loadD,
   output logic             loadE,
   output logic             loadM,
   output logic             loadW,
   output logic             flushE,
   output logic [1:0]       forwardAE,
   output logic [1:0]       forwardBE,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] stall_count
);

   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int DRN_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
   localparam logic [WAIT_W-1:0] TIMEOUT_M1 = WAIT_W'(TIMEOUT - 1);
   localparam logic [DRN_W-1:0]  DRAIN_M1   = DRN_W'(DRAIN_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_RUN, S_MEM_WAIT, S_DRAIN, S_DONE, S_ERROR
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [DRN_W-1:0]  drain_q, drain_d;
   logic [CNT_W-1:0]  stall_q, stall_d;

   logic mw, run_like, lu, busy_s;

   // A MEM_WAIT cycle whose access completes is handled exactly like a RUN cycle.
   assign mw       = mem_req & ~mem_ready;
   assign run_like = (state_q == S_RUN) | ((state_q == S_MEM_WAIT) & ~mw);
   assign lu       = run_like & MemtoRegE & RegWriteE & ((WA3E == ra1D) | (WA3E == ra2D));
   assign busy_s   = (state_q == S_RUN) | (state_q == S_MEM_WAIT) | (state_q == S_DRAIN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
         drain_q <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         drain_q <= drain_d;
         stall_q <= stall_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      drain_d = drain_q;
      stall_d = stall_q;
      if (busy_s && (mw || lu) && (stall_q != '1)) stall_d = stall_q + 1'b1;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               wait_d  = '0;
               drain_d = '0;
               stall_d = '0;
            end
         end
         S_RUN, S_MEM_WAIT: begin
            if (mw) begin
               if (state_q == S_RUN) begin
                  wait_d  = WAIT_W'(1);
                  state_d = (TIMEOUT <= 1) ? S_ERROR : S_MEM_WAIT;
               end else if (wait_q >= TIMEOUT_M1) begin
                  state_d = S_ERROR;
               end else begin
                  wait_d = wait_q + 1'b1;
               end
            end else begin
               wait_d  = '0;
               state_d = S_RUN;
               if (!lu && haltD) begin
                  state_d = S_DRAIN;
                  drain_d = '0;
               end
            end
         end
         S_DRAIN: begin
            if (!mw) begin
               if (drain_q >= DRAIN_M1) state_d = S_DONE;
               else                     drain_d = drain_q + 1'b1;
            end
         end
         default: state_d = S_ERROR;
      endcase
   end

   always_comb begin
      {loadF, loadD, loadE, loadM, loadW} = 5'b00000;
      flushE = 1'b0;
      unique case (state_q)
         S_RUN, S_MEM_WAIT: begin
            if (!mw) begin
               {loadF, loadD, loadE, loadM, loadW} = 5'b11111;
               if (lu || haltD) begin
                  loadF  = 1'b0;
                  loadD  = 1'b0;
                  flushE = 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (!mw) begin
               {loadE, loadM, loadW} = 3'b111;
               flushE = 1'b1;
            end
         end
         default: ;
      endcase
      busy  = busy_s;
      done  = (state_q == S_DONE);
      error = (state_q == S_ERROR);
   end

   // M-stage result is newer than W-stage, so it wins when both match.
   always_comb begin
      forwardAE = 2'b00;
      forwardBE = 2'b00;
      if (RegWriteM && (WA3M == ra1E))      forwardAE = 2'b10;
      else if (RegWriteW && (WA3W == ra1E)) forwardAE = 2'b01;
      if (RegWriteM && (WA3M == ra2E))      forwardBE = 2'b10;
      else if (RegWriteW && (WA3W == ra2E)) forwardBE = 2'b01;
   end

   assign stall_count = stall_q;

endmodule
